// File: rtl/uart_cmd_sequencer.sv
// Host-command front end: parses 3-byte UART headers, then loads data/op BRAM
// payloads or snapshots INFERENCE and streams it back over UART TX.
module uart_cmd_sequencer #(
    parameter int DATA_SIZE       = 2048,
    parameter int DATA_BRAM_WIDTH = 64,
    parameter int DATA_ADDRS      = 2,
    parameter int OP_ADDRS        = 1024,
    parameter int OP_SIZE         = 8,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                                                     clk_in,
    input  logic                                                     rst_in,
    input  logic [7:0]                                               rx_data_in,
    input  logic                                                     rx_valid_in,
    output logic [7:0]                                               tx_data_out,
    output logic                                                     tx_valid_out,
    input  logic                                                     tx_ready_in,
    output logic                                                     data_we_out,
    output logic [$clog2(DATA_ADDRS*DATA_SIZE/DATA_BRAM_WIDTH)-1:0]  data_addr_out,
    output logic [DATA_BRAM_WIDTH-1:0]                               data_wdata_out,
    output logic                                                     op_we_out,
    output logic [$clog2(OP_ADDRS)-1:0]                              op_addr_out,
    output logic [OP_SIZE-1:0]                                       op_wdata_out,
    input  logic [DATA_SIZE-1:0]                                     inf_data_in,
    output logic                                                     cpu_hold_out,
    output logic                                                     busy_out
);
    localparam int BPW    = DATA_BRAM_WIDTH / 8;
    localparam int WPV    = DATA_SIZE / DATA_BRAM_WIDTH;
    localparam int NBYTES = DATA_SIZE / 8;
    localparam int DA_W   = $clog2(DATA_ADDRS * WPV);
    localparam int OA_W   = $clog2(OP_ADDRS);
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int TM_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_HDR2, S_LOAD, S_OPWR, S_SNAP, S_SEND} state_t;

    state_t                     r_state, w_next;
    logic [7:0]                 r_cmd;
    logic [15:0]                r_addr;
    logic [DATA_BRAM_WIDTH-1:0] r_word;
    logic [CNT_W-1:0]           r_cnt;
    logic [TM_W-1:0]            r_timer;
    logic [DATA_SIZE-1:0]       r_snap;
    logic                       r_data_we;
    logic [DA_W-1:0]            r_data_addr;
    logic [DATA_BRAM_WIDTH-1:0] r_data_wdata;
    logic                       r_op_we;
    logic [OA_W-1:0]            r_op_addr;
    logic [OP_SIZE-1:0]         r_op_wdata;

    logic                       w_timed_state, w_timeout, w_last, w_tx_fire, w_lane_last, w_addr_ok;
    logic [DATA_BRAM_WIDTH-1:0] w_word_next;

    assign w_timed_state = (r_state == S_HDR1) || (r_state == S_HDR2) ||
                           (r_state == S_LOAD) || (r_state == S_OPWR);
    assign w_timeout   = w_timed_state && !rx_valid_in && (r_timer == TM_W'(TIMEOUT_CYCLES - 1));
    assign w_last      = (r_cnt == CNT_W'(NBYTES - 1));
    assign w_tx_fire   = (r_state == S_SEND) && tx_ready_in;
    assign w_lane_last = ((r_cnt % CNT_W'(BPW)) == CNT_W'(BPW - 1));
    assign w_addr_ok   = (32'(r_addr) < 32'(DATA_ADDRS));
    // LSB-first packing: each new byte enters at the top and slides down.
    assign w_word_next = DATA_BRAM_WIDTH'({rx_data_in, r_word} >> 8);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (rx_valid_in) w_next = S_HDR1;
            S_HDR1: if (rx_valid_in) w_next = S_HDR2;
                    else if (w_timeout) w_next = S_IDLE;
            S_HDR2: if (rx_valid_in) begin
                        case (r_cmd)
                            8'h00:   w_next = S_LOAD;
                            8'h02:   w_next = S_OPWR;
                            8'h07:   w_next = S_SNAP;
                            default: w_next = S_IDLE;
                        endcase
                    end else if (w_timeout) w_next = S_IDLE;
            S_LOAD: if (rx_valid_in && w_last) w_next = S_IDLE;
                    else if (w_timeout) w_next = S_IDLE;
            S_OPWR: if (rx_valid_in || w_timeout) w_next = S_IDLE;
            S_SNAP: w_next = S_SEND;
            S_SEND: if (w_tx_fire && w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out     = (r_state != S_IDLE);
        cpu_hold_out = (r_state == S_LOAD) || (r_state == S_SNAP) || r_data_we;
        tx_valid_out = (r_state == S_SEND);
        tx_data_out  = (r_state == S_SEND) ? r_snap[7:0] : 8'h00;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cmd        <= '0;
            r_addr       <= '0;
            r_word       <= '0;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_snap       <= '0;
            r_data_we    <= 1'b0;
            r_data_addr  <= '0;
            r_data_wdata <= '0;
            r_op_we      <= 1'b0;
            r_op_addr    <= '0;
            r_op_wdata   <= '0;
        end else begin
            r_data_we <= 1'b0;
            r_op_we   <= 1'b0;
            if (!w_timed_state || rx_valid_in) r_timer <= '0;
            else                               r_timer <= r_timer + TM_W'(1);

            case (r_state)
                S_IDLE: if (rx_valid_in) r_cmd <= rx_data_in;
                S_HDR1: if (rx_valid_in) r_addr[7:0] <= rx_data_in;
                S_HDR2: if (rx_valid_in) begin
                            r_addr[15:8] <= rx_data_in;
                            r_cnt        <= '0;
                        end
                S_LOAD: if (rx_valid_in) begin
                            r_word <= w_word_next;
                            r_cnt  <= r_cnt + CNT_W'(1);
                            // Out-of-range vectors still consume their payload, just without writes.
                            if (w_lane_last && w_addr_ok) begin
                                r_data_we    <= 1'b1;
                                r_data_wdata <= w_word_next;
                                r_data_addr  <= DA_W'(32'(r_addr) * 32'(WPV) + 32'(r_cnt) / 32'(BPW));
                            end
                        end
                S_OPWR: if (rx_valid_in) begin
                            r_op_we    <= 1'b1;
                            r_op_addr  <= OA_W'(32'(r_addr) % 32'(OP_ADDRS));
                            r_op_wdata <= OP_SIZE'(rx_data_in);
                        end
                S_SNAP: begin
                            r_snap <= inf_data_in;
                            r_cnt  <= '0;
                        end
                S_SEND: if (tx_ready_in) begin
                            r_snap <= r_snap >> 8;
                            r_cnt  <= r_cnt + CNT_W'(1);
                        end
                default: ;
            endcase
        end
    end

    assign data_we_out    = r_data_we;
    assign data_addr_out  = r_data_addr;
    assign data_wdata_out = r_data_wdata;
    assign op_we_out      = r_op_we;
    assign op_addr_out    = r_op_addr;
    assign op_wdata_out   = r_op_wdata;
endmodule
